// File: rtl/spi_xfer_sched.sv
// Two-requester SPI transfer scheduler. Arbitrates round-robin between two
// byte-transfer requesters and sequences the SPI controller's SFR bus for the
// winner: CR1 and BR writes, slave select, DR1 write, status polling,
// DR2 read, then an ack (or an err on timeout) back to that requester.
//
// Ports
//   clk, rst_n              clock, synchronous active-low reset
//   req0/1, tx0/1, ss0/1    request level, TX byte, slave index per requester
//   ack0/1, err0/1          one-cycle completion / timeout pulses
//   rx0/1                   received byte, held until the next ack
//   sfraddr_w, sfrwe,
//   spidata_o               SFR write port (0=CR1, 1=CR2, 2=BR, 3=DR1)
//   sfraddr_r, sfr_data_i   SFR read port (3=status, 5=DR2), one-cycle read latency
//   spssn_o                 active-low slave selects
//   busy                    high whenever a transfer is in progress
module spi_xfer_sched #(
  parameter logic [7:0]      CR1_VAL = 8'h10,
  parameter logic [7:0]      BR_VAL  = 8'h02,
  parameter int unsigned     TO_W    = 12,
  parameter logic [TO_W-1:0] TO_MAX  = TO_W'(12'hFFF)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic [7:0] tx0,
  input  logic [2:0] ss0,
  output logic       ack0,
  output logic       err0,
  output logic [7:0] rx0,
  input  logic       req1,
  input  logic [7:0] tx1,
  input  logic [2:0] ss1,
  output logic       ack1,
  output logic       err1,
  output logic [7:0] rx1,
  output logic [1:0] sfraddr_w,
  output logic       sfrwe,
  output logic [7:0] spidata_o,
  output logic [2:0] sfraddr_r,
  input  logic [7:0] sfr_data_i,
  output logic [7:0] spssn_o,
  output logic       busy
);

  localparam logic [1:0] A_CR1    = 2'd0;
  localparam logic [1:0] A_BR     = 2'd2;
  localparam logic [1:0] A_DR1    = 2'd3;
  localparam logic [2:0] A_STATUS = 3'd3;
  localparam logic [2:0] A_DR2    = 3'd5;

  typedef enum logic [3:0] {
    S_IDLE, S_W_CR1, S_W_BR, S_SEL, S_W_DR,
    S_WAIT_CLR, S_WAIT_DONE, S_RD_ADDR, S_RD_CAP, S_RESP
  } state_t;

  state_t          r_state;
  logic            r_rr;
  logic            r_gnt;
  logic [7:0]      r_tx;
  logic [2:0]      r_ss;
  logic [TO_W-1:0] r_to;

  logic w_both;
  logic w_pick;
  logic w_to_hit;

  // Contention resolves by the rr pointer; otherwise the lone requester wins.
  assign w_both   = req0 & req1;
  assign w_pick   = w_both ? r_rr : req1;
  // Last cycle of the wait budget: the abort is registered, so the err pulse
  // lands TO_MAX cycles after entering the wait state.
  assign w_to_hit = (r_to == TO_MAX - TO_W'(1));

  // Sequencer with all outputs registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_rr      <= 1'b0;
      r_gnt     <= 1'b0;
      r_tx      <= 8'h00;
      r_ss      <= 3'd0;
      r_to      <= '0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      err0      <= 1'b0;
      err1      <= 1'b0;
      rx0       <= 8'h00;
      rx1       <= 8'h00;
      sfrwe     <= 1'b0;
      sfraddr_w <= A_CR1;
      spidata_o <= 8'h00;
      sfraddr_r <= A_STATUS;
      spssn_o   <= 8'hFF;
      busy      <= 1'b0;
    end else begin
      ack0  <= 1'b0;
      ack1  <= 1'b0;
      err0  <= 1'b0;
      err1  <= 1'b0;
      sfrwe <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req0 | req1) begin
            r_gnt     <= w_pick;
            r_tx      <= w_pick ? tx1 : tx0;
            r_ss      <= w_pick ? ss1 : ss0;
            if (w_both) r_rr <= ~r_rr;
            sfrwe     <= 1'b1;
            sfraddr_w <= A_CR1;
            spidata_o <= CR1_VAL;
            busy      <= 1'b1;
            r_state   <= S_W_CR1;
          end
        end
        S_W_CR1: begin
          sfrwe     <= 1'b1;
          sfraddr_w <= A_BR;
          spidata_o <= BR_VAL;
          r_state   <= S_W_BR;
        end
        S_W_BR: begin
          spssn_o <= ~(8'b1 << r_ss);
          r_state <= S_SEL;
        end
        S_SEL: begin
          // DR1 write kicks off the shift in the SPI block.
          sfrwe     <= 1'b1;
          sfraddr_w <= A_DR1;
          spidata_o <= r_tx;
          r_state   <= S_W_DR;
        end
        S_W_DR: begin
          sfraddr_r <= A_STATUS;
          r_to      <= '0;
          r_state   <= S_WAIT_CLR;
        end
        S_WAIT_CLR, S_WAIT_DONE: begin
          // First wait out a stale done flag, then wait for the new one.
          if (r_state == S_WAIT_CLR && !sfr_data_i[0]) begin
            r_to    <= '0;
            r_state <= S_WAIT_DONE;
          end else if (r_state == S_WAIT_DONE && sfr_data_i[0]) begin
            sfraddr_r <= A_DR2;
            r_state   <= S_RD_ADDR;
          end else if (w_to_hit) begin
            err0    <= ~r_gnt;
            err1    <= r_gnt;
            spssn_o <= 8'hFF;
            busy    <= 1'b0;
            r_to    <= '0;
            r_state <= S_IDLE;
          end else begin
            r_to <= r_to + TO_W'(1);
          end
        end
        S_RD_ADDR: begin
          r_state <= S_RD_CAP;
        end
        S_RD_CAP: begin
          // Read data lags the address by one cycle, so DR2 is valid here.
          if (r_gnt) rx1 <= sfr_data_i;
          else       rx0 <= sfr_data_i;
          ack0      <= ~r_gnt;
          ack1      <= r_gnt;
          spssn_o   <= 8'hFF;
          sfraddr_r <= A_STATUS;
          r_state   <= S_RESP;
        end
        S_RESP: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_xfer_sched.sv
// Randomized bench for spi_xfer_sched with a behavioural SPI status/DR2 model
// and a transfer-level scoreboard.
module tb_spi_xfer_sched;

  localparam logic [7:0] CR1 = 8'h10;
  localparam logic [7:0] BR  = 8'h02;
  localparam int         TO_LIM = 4095;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [7:0] tx0 = 8'h00, tx1 = 8'h00;
  logic [2:0] ss0 = 3'd0, ss1 = 3'd0;
  logic       ack0, ack1, err0, err1;
  logic [7:0] rx0, rx1;
  logic [1:0] sfraddr_w;
  logic       sfrwe;
  logic [7:0] spidata_o;
  logic [2:0] sfraddr_r;
  logic [7:0] sfr_data_i = 8'h00;
  logic [7:0] spssn_o;
  logic       busy;

  spi_xfer_sched #(.CR1_VAL(CR1), .BR_VAL(BR), .TO_W(12), .TO_MAX(12'hFFF)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .tx0(tx0), .ss0(ss0), .ack0(ack0), .err0(err0), .rx0(rx0),
    .req1(req1), .tx1(tx1), .ss1(ss1), .ack1(ack1), .err1(err1), .rx1(rx1),
    .sfraddr_w(sfraddr_w), .sfrwe(sfrwe), .spidata_o(spidata_o),
    .sfraddr_r(sfraddr_r), .sfr_data_i(sfr_data_i),
    .spssn_o(spssn_o), .busy(busy)
  );

  always #5 clk = ~clk;

  // SPI block model: done clears cfg_clr edges after a DR1 write and sets
  // cfg_shift edges after that; status/DR2 reads have one cycle of latency.
  longint     cyc = 0;
  longint     clr_at = -1, set_at = -1;
  logic       m_done = 1'b0;
  logic [7:0] m_dr2 = 8'h00;
  int         cfg_clr = 1, cfg_shift = 10;
  bit         cfg_never = 1'b0;
  logic [7:0] cfg_dr2 = 8'h00;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    sfr_data_i <= (sfraddr_r == 3'd3) ? {7'd0, m_done} :
                  ((sfraddr_r == 3'd5) ? m_dr2 : 8'h00);
    if (sfrwe && sfraddr_w == 2'd3) begin
      clr_at <= cyc + longint'(cfg_clr);
      set_at <= cfg_never ? -1 : cyc + longint'(cfg_clr + cfg_shift);
      m_dr2  <= cfg_dr2;
    end
    if (cyc == clr_at) m_done <= 1'b0;
    if (cyc == set_at) m_done <= 1'b1;
  end

  // Scoreboard state
  int         n_chk = 0, n_fail = 0;
  int         cur = -1;
  int         widx = 0, phase = 0;
  logic [7:0] cur_tx = 8'h00, cur_dr2 = 8'h00;
  logic [2:0] cur_ss = 3'd0;
  longint     t_cr1 = 0, t_dr = 0, t_wd = 0, t_resp = 0, exp_to = 0, exp_ack = 0;
  bit         sel_on = 1'b0, m_rr = 1'b0;
  logic [7:0] m_rx [2] = '{8'h00, 8'h00};
  int         n_ack [2] = '{0, 0};
  int         n_err [2] = '{0, 0};
  bit         reraise [2] = '{1'b0, 1'b0};
  bit         b2b_pend [2] = '{1'b0, 1'b0};
  int         b2b_done = 0;
  int         ackq [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_rst();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_spssn", 32'(spssn_o), 32'hFF);
    chk("rst_sfrwe", 32'(sfrwe), 0);
    chk("rst_waddr", 32'(sfraddr_w), 0);
    chk("rst_wdata", 32'(spidata_o), 0);
    chk("rst_raddr", 32'(sfraddr_r), 3);
    chk("rst_ackerr", 32'({ack0, ack1, err0, err1}), 0);
    chk("rst_rx0", 32'(rx0), 0);
    chk("rst_rx1", 32'(rx1), 0);
  endtask

  // One cycle: sample at the falling edge, score, then update requesters.
  task automatic tick();
    bit         resp_now, err_now, br_now, a, e;
    logic [1:0] ea;
    logic [7:0] ed, exp_ss;
    int         et;
    longint     deadline;
    @(negedge clk);
    resp_now = 0; err_now = 0; br_now = 0;

    if (sfrwe) begin
      if (cur < 0 && sfraddr_w == 2'd0) begin
        chk("grant_had_req", 32'(req0 | req1), 1);
        if (req0 && req1) begin cur = int'(m_rr); m_rr = !m_rr; end
        else cur = req1 ? 1 : 0;
        cur_tx = (cur == 1) ? tx1 : tx0;
        cur_ss = (cur == 1) ? ss1 : ss0;
        widx = 0; phase = 0; t_cr1 = cyc;
        if (b2b_pend[cur]) begin
          chk("b2b_latency", 32'(cyc - t_resp), 2);
          b2b_done++;
        end
        b2b_pend[0] = 0; b2b_pend[1] = 0;
      end
      if (cur < 0 || widx > 2) chk("unexpected_write", 32'(sfrwe), 0);
      else begin
        case (widx)
          0:       begin ea = 2'd0; ed = CR1;    et = 0; end
          1:       begin ea = 2'd2; ed = BR;     et = 1; end
          default: begin ea = 2'd3; ed = cur_tx; et = 3; end
        endcase
        chk("wr_addr", 32'(sfraddr_w), 32'(ea));
        chk("wr_data", 32'(spidata_o), 32'(ed));
        chk("wr_slot", 32'(cyc - t_cr1), 32'(et));
        if (widx == 1) br_now = 1;
        if (widx == 2) begin
          phase = 1; t_dr = cyc; exp_to = cyc + 1 + TO_LIM; cur_dr2 = cfg_dr2;
        end
        widx++;
      end
    end

    for (int i = 0; i < 2; i++) begin
      a = (i == 1) ? ack1 : ack0;
      e = (i == 1) ? err1 : err0;
      if (a || e) begin
        chk("ack_err_excl", 32'(a & e), 0);
        chk("resp_owner", 32'(i), 32'(cur));
        if (cur == i) begin
          if (a) begin
            chk("ack_after_done", 32'(phase), 3);
            chk("ack_cycle", 32'(cyc), 32'(exp_ack));
            m_rx[i] = cur_dr2; n_ack[i]++; ackq.push_back(i);
          end else begin
            chk("err_phase", 32'(phase == 1 || phase == 2), 1);
            chk("err_cycle", 32'(cyc), 32'(exp_to));
            n_err[i]++; err_now = 1;
          end
          resp_now = 1; cur = -1; sel_on = 0; t_resp = cyc;
          if (reraise[i]) begin
            reraise[i] = 0; b2b_pend[i] = 1;
            if (i == 1) tx1 = 8'($urandom); else tx0 = 8'($urandom);
          end else if (i == 1) req1 = 1'b0;
          else req0 = 1'b0;
        end
      end
    end

    if (cur >= 0 && phase == 1 && cyc > t_dr) begin
      if (!sfr_data_i[0]) begin phase = 2; t_wd = cyc + 1; exp_to = t_wd + TO_LIM; end
    end else if (cur >= 0 && phase == 2 && cyc >= t_wd) begin
      if (sfr_data_i[0]) begin phase = 3; exp_ack = cyc + 3; end
    end

    if (cur >= 0) begin
      deadline = (phase == 0) ? t_cr1 + 3 : ((phase == 3) ? exp_ack : exp_to);
      if (cyc > deadline) begin
        chk("resp_overdue", 32'(ack0 | ack1 | err0 | err1), 1);
        cur = -1; sel_on = 0; req0 = 1'b0; req1 = 1'b0;
      end
    end

    exp_ss = 8'hFF;
    if (sel_on) exp_ss = ~(8'b1 << cur_ss);
    chk("spssn", 32'(spssn_o), 32'(exp_ss));
    chk("rx0", 32'(rx0), 32'(m_rx[0]));
    chk("rx1", 32'(rx1), 32'(m_rx[1]));
    if (!err_now) chk("busy", 32'(busy), 32'(cur >= 0 || resp_now));
    if (br_now) sel_on = 1;
  endtask

  task automatic raise(input int i, input logic [7:0] tx, input logic [2:0] ss);
    if (i == 1) begin req1 = 1'b1; tx1 = tx; ss1 = ss; end
    else begin req0 = 1'b1; tx0 = tx; ss0 = ss; end
  endtask

  task automatic wait_idle(input int budget);
    for (int k = 0; k < budget; k++) begin
      if (!req0 && !req1 && cur < 0 && !busy) return;
      tick();
    end
    chk("drain_budget", 32'(req0 | req1 | busy), 0);
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int         base, na, ne;
    logic [7:0] t, rx1_before;
    logic [2:0] s;
    bit [1:0]   pat;

    repeat (2) @(negedge clk);
    check_rst();
    rst_n = 1'b1;
    repeat (2) tick();

    // Single transfer, done 20 edges after the DR1 write
    cfg_clr = 1; cfg_shift = 19; cfg_dr2 = 8'h3C; cfg_never = 0;
    raise(0, 8'hA5, 3'd2);
    wait_idle(300);
    chk("single_ack0", 32'(n_ack[0]), 1);
    chk("single_rx0", 32'(rx0), 32'h3C);
    chk("single_spssn_idle", 32'(spssn_o), 32'hFF);

    // Contention, three rounds; rr starts at requester 0
    for (int r = 0; r < 3; r++) begin
      cfg_clr = 1; cfg_shift = int'($urandom_range(2, 12)); cfg_dr2 = 8'($urandom);
      t = 8'($urandom); s = 3'($urandom);
      base = ackq.size();
      raise(0, t, s);
      raise(1, ~t, s + 3'd1);
      wait_idle(400);
      chk("cont_acks", 32'(ackq.size() - base), 2);
      if (ackq.size() >= base + 2) begin
        chk("cont_first", 32'(ackq[base]), (r == 1) ? 1 : 0);
        chk("cont_second", 32'(ackq[base + 1]), (r == 1) ? 0 : 1);
      end
    end

    // Stale done: bit0 still set from the previous transfer
    cfg_clr = 6; cfg_shift = 8; cfg_dr2 = 8'h5A;
    na = n_ack[1];
    raise(1, 8'hC3, 3'd7);
    wait_idle(300);
    chk("stale_ack1", 32'(n_ack[1] - na), 1);
    chk("stale_rx1", 32'(rx1), 32'h5A);

    // Timeout: done never returns
    cfg_clr = 1; cfg_never = 1; cfg_dr2 = 8'hEE;
    na = n_ack[1]; ne = n_err[1]; rx1_before = rx1;
    raise(1, 8'h77, 3'd1);
    wait_idle(TO_LIM + 200);
    chk("to_err1", 32'(n_err[1] - ne), 1);
    chk("to_no_ack1", 32'(n_ack[1] - na), 0);
    chk("to_rx1_kept", 32'(rx1), 32'(rx1_before));
    cfg_never = 0;
    repeat (3) tick();

    // Reset during WAIT_DONE
    cfg_clr = 1; cfg_shift = 40; cfg_dr2 = 8'h99;
    raise(0, 8'h42, 3'd5);
    for (int k = 0; k < 200; k++) begin
      tick();
      if (phase == 2 && cyc >= t_wd + 3) break;
    end
    chk("rst_mid_reached", 32'(phase), 2);
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    check_rst();
    cur = -1; phase = 0; sel_on = 0; m_rr = 0;
    m_rx[0] = 8'h00; m_rx[1] = 8'h00;
    reraise[0] = 0; reraise[1] = 0; b2b_pend[0] = 0; b2b_pend[1] = 0;
    rst_n = 1'b1;
    repeat (60) tick();

    // Back-to-back on requester 0
    cfg_clr = 2; cfg_shift = 5; cfg_dr2 = 8'h81;
    na = n_ack[0];
    raise(0, 8'h11, 3'd4);
    reraise[0] = 1;
    wait_idle(400);
    chk("b2b_seen", 32'(b2b_done), 1);
    chk("b2b_acks", 32'(n_ack[0] - na), 2);

    // Random traffic
    for (int r = 0; r < 25; r++) begin
      pat = 2'($urandom_range(1, 3));
      cfg_clr = int'($urandom_range(1, 4));
      cfg_shift = int'($urandom_range(1, 25));
      cfg_dr2 = 8'($urandom);
      if (pat[0]) begin
        raise(0, 8'($urandom), 3'($urandom));
        reraise[0] = ($urandom_range(0, 3) == 0);
      end
      if (pat[1]) begin
        raise(1, 8'($urandom), 3'($urandom));
        reraise[1] = ($urandom_range(0, 3) == 0);
      end
      wait_idle(1000);
    end
    chk("final_idle_spssn", 32'(spssn_o), 32'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
